// File: rtl/display_load_scheduler_pkg.sv
// Shared types and helpers for the display load scheduler.
//   DISP_DATA_W : default width of a display word
//   state_e     : scheduler FSM states
//   idx_w()     : index width for n items ($clog2 with a floor of 1);
//                 used for the source index and the dwell counter
package display_load_scheduler_pkg;

    localparam int DISP_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_load_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches the request vector starting one above the last granted index,
// wrapping at NUM_SRC, and returns the first requester found.
//   req       : request vector
//   ptr       : index of the most recent grant
//   grant     : one-hot grant (zero when nothing requests)
//   grant_idx : binary index of the granted source
//   any_req   : at least one request is pending
module display_load_scheduler_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [SRC_W-1:0]   grant_idx,
    output logic               any_req
);

    logic             found_s;
    logic [SRC_W-1:0] cand_s;

    // Rotating priority search; the first hit after ptr wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand_s = SRC_W'((int'(ptr) + k) % NUM_SRC);
            if (!found_s && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/display_load_scheduler.sv
// Shares one seven-segment display driver between NUM_SRC requesters.
// A round-robin winner's word is captured, presented with a one-cycle
// load pulse and ack, and then held for DWELL_CYCLES before the next grant.
//   clk, rst     : clock and synchronous active-high reset
//   src_valid    : per-source request, held until acked
//   src_data     : flattened words, source i at [i*DATA_W +: DATA_W]
//   src_ack      : one-hot one-cycle acknowledge to the granted source
//   disp_load    : one-cycle load pulse to the display driver
//   disp_number  : word presented to the display driver
//   cur_src      : index of the last granted source
//   busy         : high while loading or dwelling
module display_load_scheduler
    import display_load_scheduler_pkg::*;
#(
    parameter int  NUM_SRC      = 4,
    parameter int  DWELL_CYCLES = 50_000_000,
    parameter int  DATA_W       = DISP_DATA_W,
    localparam int SRC_W        = idx_w(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ack,
    output logic                      disp_load,
    output logic [DATA_W-1:0]         disp_number,
    output logic [SRC_W-1:0]          cur_src,
    output logic                      busy
);

    localparam int CNT_W = idx_w(DWELL_CYCLES);

    state_e              state_r;
    logic [SRC_W-1:0]    ptr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [NUM_SRC-1:0]  ack_r;
    logic                load_r;
    logic [DATA_W-1:0]   number_r;
    logic [SRC_W-1:0]    cur_src_r;
    logic                busy_r;

    logic [NUM_SRC-1:0]  grant_s;
    logic [SRC_W-1:0]    grant_idx_s;
    logic                any_req_s;
    logic [DATA_W-1:0]   sel_word_s;

    display_load_scheduler_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_arb (
        .req       (src_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any_req   (any_req_s)
    );

    // Word of the arbitration winner, selected by the one-hot grant.
    always_comb begin
        sel_word_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_s[i]) begin
                sel_word_s = src_data[i*DATA_W +: DATA_W];
            end else begin
                sel_word_s = sel_word_s;
            end
        end
    end

    // Scheduler FSM with dwell counter, round-robin pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            // Pointing at the last source makes source 0 the first to win.
            ptr_r     <= SRC_W'(NUM_SRC - 1);
            cnt_r     <= '0;
            ack_r     <= '0;
            load_r    <= 1'b0;
            number_r  <= '0;
            cur_src_r <= '0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        state_r   <= ST_LOAD;
                        number_r  <= sel_word_s;
                        cur_src_r <= grant_idx_s;
                        ptr_r     <= grant_idx_s;
                        ack_r     <= grant_s;
                        load_r    <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        ack_r  <= '0;
                        load_r <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_DWELL;
                    cnt_r   <= CNT_W'(DWELL_CYCLES - 1);
                    ack_r   <= '0;
                    load_r  <= 1'b0;
                    busy_r  <= 1'b1;
                end
                ST_DWELL: begin
                    // Requests are not looked at until the dwell has expired.
                    if (cnt_r == '0) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r  <= cnt_r - CNT_W'(1);
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ack_r   <= '0;
                    load_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign src_ack     = ack_r;
    assign disp_load   = load_r;
    assign disp_number = number_r;
    assign cur_src     = cur_src_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_display_load_scheduler.sv
// Self-checking bench for display_load_scheduler (NUM_SRC=4, DWELL_CYCLES=4).
// Expected loads are queued as stimulus is driven; a negedge monitor pops
// and compares them whenever the DUT pulses disp_load.
module tb_display_load_scheduler;

    localparam int NUM_SRC = 4;
    localparam int DWELL   = 4;
    localparam int DATA_W  = 32;

    logic                      clk_s = 1'b0;
    logic                      rst_s;
    logic [NUM_SRC-1:0]        src_valid_s;
    logic [NUM_SRC*DATA_W-1:0] src_data_s;
    logic [NUM_SRC-1:0]        src_ack_s;
    logic                      disp_load_s;
    logic [DATA_W-1:0]         disp_number_s;
    logic [1:0]                cur_src_s;
    logic                      busy_s;

    display_load_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .DWELL_CYCLES (DWELL),
        .DATA_W       (DATA_W)
    ) dut (
        .clk         (clk_s),
        .rst         (rst_s),
        .src_valid   (src_valid_s),
        .src_data    (src_data_s),
        .src_ack     (src_ack_s),
        .disp_load   (disp_load_s),
        .disp_number (disp_number_s),
        .cur_src     (cur_src_s),
        .busy        (busy_s)
    );

    always #5 clk_s = ~clk_s;

    int cyc = 0;
    always @(posedge clk_s) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    logic [NUM_SRC-1:0] drop_mask;
    int                loads_seen = 0;
    int                n_checks   = 0;
    int                n_errors   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic expect_load(input int idx, input logic [31:0] d, input int at);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        src_data_s[i*DATA_W +: DATA_W] = w;
    endtask

    // Advance to the next sampling point; sources drop their request once acked.
    task automatic step();
        @(negedge clk_s);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_ack_s[i] && drop_mask[i]) src_valid_s[i] = 1'b0;
        end
    endtask

    // Wait (bounded) until every expected load has been seen and the DUT is idle.
    task automatic settle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy_s) && n < budget) begin
            step();
            n++;
        end
        check_eq("settle_timeout", 64'(sb.size() != 0 || busy_s), 64'(0));
    endtask

    // Scoreboard monitor plus per-cycle invariants.
    always @(negedge clk_s) begin
        check_eq("ack_onehot0", 64'($onehot0(src_ack_s)), 64'(1));
        check_eq("load_eq_or_ack", 64'(disp_load_s), 64'(|src_ack_s));
        if (disp_load_s) begin
            loads_seen++;
            if (sb.size() == 0) begin
                check_eq("unexpected_load", 64'(disp_load_s), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check_eq("sb_ack", 64'(src_ack_s), 64'(4'b0001 << mon_e.idx));
                check_eq("sb_number", 64'(disp_number_s), 64'(mon_e.data));
                check_eq("sb_cur_src", 64'(cur_src_s), 64'(mon_e.idx));
                check_eq("sb_cycle", 64'(cyc), 64'(mon_e.at));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int base;
        int n;

        rst_s       = 1'b1;
        src_valid_s = 4'b1111;
        src_data_s  = '0;
        drop_mask   = 4'b1111;
        set_word(0, 32'hDEADBEEF);
        set_word(1, 32'h11111111);
        set_word(2, 32'h22222222);
        set_word(3, 32'h33333333);

        // Reset held with every source requesting: outputs stay cleared.
        for (int k = 0; k < 10; k++) begin
            step();
            check_eq("rst_load", 64'(disp_load_s), 64'(0));
            check_eq("rst_ack", 64'(src_ack_s), 64'(0));
            check_eq("rst_number", 64'(disp_number_s), 64'(0));
            check_eq("rst_cur_src", 64'(cur_src_s), 64'(0));
            check_eq("rst_busy", 64'(busy_s), 64'(0));
        end
        rst_s       = 1'b0;
        src_valid_s = 4'b0001;
        c = cyc;
        expect_load(0, 32'hDEADBEEF, c + 1);
        settle(40);

        // Single request from source 2: busy spans LOAD plus DWELL.
        set_word(2, 32'h0000_1234);
        src_valid_s[2] = 1'b1;
        c = cyc;
        expect_load(2, 32'h0000_1234, c + 1);
        for (int k = 1; k <= 6; k++) begin
            step();
            check_eq("single_busy", 64'(busy_s), 64'(k <= 5));
        end
        check_eq("single_number", 64'(disp_number_s), 64'(32'h0000_1234));
        settle(40);

        // Fresh pointer, all four requesting continuously: 0,1,2,3,0 every 6 cycles.
        rst_s = 1'b1;
        step();
        step();
        rst_s     = 1'b0;
        drop_mask = 4'b0000;
        for (int i = 0; i < NUM_SRC; i++) set_word(i, 32'hA0 + 32'(i));
        src_valid_s = 4'b1111;
        c    = cyc;
        base = loads_seen;
        for (int j = 0; j < 5; j++) expect_load(j % 4, 32'hA0 + 32'(j % 4), c + 1 + (DWELL + 2) * j);
        n = 0;
        while (loads_seen < base + 5 && n < 60) begin
            step();
            n++;
        end
        src_valid_s = 4'b0000;
        check_eq("rr_timeout", 64'(loads_seen >= base + 5), 64'(1));
        drop_mask = 4'b1111;
        settle(40);

        // Source 1 requests only during DWELL and withdraws; source 3 wins next.
        set_word(0, 32'hB0B0_0000);
        set_word(1, 32'h1111_0001);
        set_word(3, 32'h3333_0003);
        src_valid_s[0] = 1'b1;
        c = cyc;
        expect_load(0, 32'hB0B0_0000, c + 1);
        expect_load(3, 32'h3333_0003, c + 7);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 2) begin
                src_valid_s[1] = 1'b1;
                src_valid_s[3] = 1'b1;
            end
            if (k == 5) src_valid_s[1] = 1'b0;
        end
        settle(40);

        // Reset during the LOAD cycle: grant lost, source 0 served again afterwards.
        drop_mask = 4'b0000;
        set_word(0, 32'h5A5A_0000);
        src_valid_s[0] = 1'b1;
        c = cyc;
        expect_load(0, 32'h5A5A_0000, c + 1);
        step();
        rst_s = 1'b1;
        step();
        check_eq("rload_load", 64'(disp_load_s), 64'(0));
        check_eq("rload_ack", 64'(src_ack_s), 64'(0));
        check_eq("rload_number", 64'(disp_number_s), 64'(0));
        check_eq("rload_busy", 64'(busy_s), 64'(0));
        rst_s = 1'b0;
        drop_mask = 4'b1111;
        expect_load(0, 32'h5A5A_0000, c + 3);
        settle(40);

        // Reset during DWELL clears the displayed word.
        set_word(1, 32'h7777_0001);
        src_valid_s[1] = 1'b1;
        c = cyc;
        expect_load(1, 32'h7777_0001, c + 1);
        step();
        step();
        step();
        check_eq("rdwell_number_pre", 64'(disp_number_s), 64'(32'h7777_0001));
        check_eq("rdwell_busy_pre", 64'(busy_s), 64'(1));
        rst_s = 1'b1;
        step();
        check_eq("rdwell_number", 64'(disp_number_s), 64'(0));
        check_eq("rdwell_busy", 64'(busy_s), 64'(0));
        rst_s = 1'b0;
        settle(40);

        // One load, then a long idle stretch keeps the last word on display.
        set_word(2, 32'hCAFEF00D);
        src_valid_s[2] = 1'b1;
        c = cyc;
        expect_load(2, 32'hCAFEF00D, c + 1);
        settle(40);
        for (int k = 0; k < 100; k++) begin
            step();
            check_eq("idle_number", 64'(disp_number_s), 64'(32'hCAFEF00D));
            check_eq("idle_load", 64'(disp_load_s), 64'(0));
            check_eq("idle_busy", 64'(busy_s), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
